timer_bus_responder: RTL and testbench



---
 rtl/timer_bus_responder.sv | 161 ++++++++++++++++
 tb/tb_timer_bus_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_responder.sv
// Timer/compare peripheral on the CPU data bus (Dw* signals).
// Prescaled 32-bit up-counter, compare match with optional auto-reload,
// sticky MATCH/OVERRUN flags and a level interrupt (MATCH & IE).
// Optional input capture unit enabled by defining TIMER_CAPTURE_EN.
module timer_bus_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0100,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
`ifdef TIMER_CAPTURE_EN
  input  logic        iCapture,
`endif
  output logic [31:0] DwReadData,
  output logic        oIRQ
);

  // Bus decode
  logic        sel;
  logic [2:0]  off;
  logic        wrAcc;
  logic [31:0] wrMask;
  logic        wrCtrl, clrPulse, wrPre, wrCmp, wrCnt, wrStat;

  // Architectural state
  logic                  ctrlEn, ctrlIe, ctrlReload;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [31:0]           compare, count;
  logic                  stMatch, stOverrun;
  logic                  stCapf;
  logic [31:0]           capture;

  logic        tick, hit;
  logic [31:0] prescaleExt;
  logic [31:0] rdata;
  logic        unusedAddr;

  assign sel        = (DwAddress[31:5] == BASE_ADDR[31:5]);
  assign off        = DwAddress[4:2];
  assign unusedAddr = ^DwAddress[1:0];
  assign wrAcc      = sel & DwWriteEnable;
  assign wrMask     = {{8{DwByteEnable[3]}}, {8{DwByteEnable[2]}},
                       {8{DwByteEnable[1]}}, {8{DwByteEnable[0]}}};

  // CTRL and STATUS fields all live in byte lane 0
  assign wrCtrl   = wrAcc & (off == 3'd0) & DwByteEnable[0];
  assign clrPulse = wrCtrl & DwWriteData[3];
  assign wrPre    = wrAcc & (off == 3'd1) & (|DwByteEnable);
  assign wrCmp    = wrAcc & (off == 3'd2) & (|DwByteEnable);
  assign wrCnt    = wrAcc & (off == 3'd3) & (|DwByteEnable);
  assign wrStat   = wrAcc & (off == 3'd4) & DwByteEnable[0];

  // A PRESCALE write or CLR restarts the prescaler and suppresses this cycle's tick
  assign tick = ctrlEn & (pcnt == prescale) & ~wrPre & ~clrPulse;
  assign hit  = tick & (count == compare);

  assign oIRQ = stMatch & ctrlIe;

  // Main register file, prescaler and counter update
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ctrlEn     <= 1'b0;
      ctrlIe     <= 1'b0;
      ctrlReload <= 1'b0;
      prescale   <= '0;
      pcnt       <= '0;
      compare    <= '0;
      count      <= '0;
      stMatch    <= 1'b0;
      stOverrun  <= 1'b0;
    end else begin
      if (wrCtrl) begin
        ctrlEn     <= DwWriteData[0];
        ctrlIe     <= DwWriteData[1];
        ctrlReload <= DwWriteData[2];
      end
      if (wrPre) begin
        prescale <= (prescale & ~wrMask[PRESCALE_W-1:0]) |
                    (DwWriteData[PRESCALE_W-1:0] & wrMask[PRESCALE_W-1:0]);
      end
      if (wrCmp) begin
        compare <= (compare & ~wrMask) | (DwWriteData & wrMask);
      end

      if (clrPulse || wrPre) begin
        pcnt <= '0;
      end else if (ctrlEn) begin
        pcnt <= (pcnt == prescale) ? '0 : pcnt + 1'b1;
      end

      // Bus write wins over the tick; wrap past all-ones is silent
      if (wrCnt) begin
        count <= (count & ~wrMask) | (DwWriteData & wrMask);
      end else if (clrPulse) begin
        count <= '0;
      end else if (tick) begin
        count <= (hit && ctrlReload) ? 32'd0 : count + 32'd1;
      end

      // Hardware set beats W1C in the same cycle
      stMatch   <= hit | (stMatch & ~(wrStat & DwWriteData[0]));
      stOverrun <= (hit & stMatch) | (stOverrun & ~(wrStat & DwWriteData[1]));
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic capSync1, capSync2, capPrev, capPulse;

  // Two-flop synchroniser, registered rising-edge detect, then capture
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      capSync1 <= 1'b0;
      capSync2 <= 1'b0;
      capPrev  <= 1'b0;
      capPulse <= 1'b0;
      capture  <= '0;
      stCapf   <= 1'b0;
    end else begin
      capSync1 <= iCapture;
      capSync2 <= capSync1;
      capPrev  <= capSync2;
      capPulse <= capSync2 & ~capPrev;
      if (capPulse) begin
        capture <= count;
      end
      stCapf <= capPulse | (stCapf & ~(wrStat & DwWriteData[2]));
    end
  end
`else
  assign capture = 32'd0;
  assign stCapf  = 1'b0;
`endif

  // Zero-extend the prescaler for readback
  always_comb begin
    prescaleExt                   = '0;
    prescaleExt[PRESCALE_W-1:0]   = prescale;
  end

  // Combinational read mux, no side effects
  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = {29'd0, ctrlReload, ctrlIe, ctrlEn};
      3'd1:    rdata = prescaleExt;
      3'd2:    rdata = compare;
      3'd3:    rdata = count;
      3'd4:    rdata = {29'd0, stCapf, stOverrun, stMatch};
      3'd5:    rdata = capture;
      default: rdata = '0;
    endcase
  end

  assign DwReadData = (sel & DwReadEnable) ? rdata : 32'hzzzzzzzz;

endmodule

// File: tb/tb_timer_bus_responder.sv
// Self-checking bench for timer_bus_responder: table-driven register
// accesses, then hand-written multi-cycle timing sequences.
module tb_timer_bus_responder;

  localparam logic [31:0] BASE = 32'hFFFF0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_PRE  = BASE + 32'h04;
  localparam logic [31:0] A_CMP  = BASE + 32'h08;
  localparam logic [31:0] A_CNT  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;
  localparam logic [31:0] A_CAP  = BASE + 32'h14;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        DwReadEnable, DwWriteEnable;
  logic [3:0]  DwByteEnable;
  logic [31:0] DwAddress, DwWriteData;
  logic [31:0] DwReadData;
  logic        oIRQ;
`ifdef TIMER_CAPTURE_EN
  logic        iCapture;
`endif

  timer_bus_responder #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .DwReadEnable  (DwReadEnable),
    .DwWriteEnable (DwWriteEnable),
    .DwByteEnable  (DwByteEnable),
    .DwAddress     (DwAddress),
    .DwWriteData   (DwWriteData),
`ifdef TIMER_CAPTURE_EN
    .iCapture      (iCapture),
`endif
    .DwReadData    (DwReadData),
    .oIRQ          (oIRQ)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        doWr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        allowZ;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic        allowZ;
  } sb_t;

  vec_t vecs[$];
  sb_t  expQ[$];
  int   nChecks = 0;
  int   nPass   = 0;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp,
                        input logic allowZ);
    logic ok;
    ok = (act === exp) || (allowZ && (act === 32'hzzzzzzzz));
    nChecks++;
    if (ok) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge iCLK);
    DwAddress     = a;
    DwWriteData   = d;
    DwByteEnable  = be;
    DwWriteEnable = 1'b1;
    @(posedge iCLK);
    #1;
    DwWriteEnable = 1'b0;
    DwByteEnable  = 4'h0;
  endtask

  // Push expectation, strobe the read, then pop and compare
  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e,
                    input logic allowZ = 1'b0);
    sb_t s;
    expQ.push_back('{name: name, exp: e, allowZ: allowZ});
    DwAddress    = a;
    DwReadEnable = 1'b1;
    #1;
    s = expQ.pop_front();
    report(s.name, DwReadData, s.exp, s.allowZ);
    DwReadEnable = 1'b0;
  endtask

  task automatic irq(input string name, input logic e);
    report(name, {31'd0, oIRQ}, {31'd0, e}, 1'b0);
  endtask

  function automatic void addVec(input string n, input logic [31:0] a, input logic w,
                                 input logic [3:0] be, input logic [31:0] d,
                                 input logic [31:0] e, input logic z);
    vecs.push_back('{name: n, addr: a, doWr: w, be: be, wdata: d, exp: e, allowZ: z});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrapSeq [7];
    wrapSeq = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};

    iRST = 1'b1; DwReadEnable = 1'b0; DwWriteEnable = 1'b0;
    DwByteEnable = 4'h0; DwAddress = '0; DwWriteData = '0;
`ifdef TIMER_CAPTURE_EN
    iCapture = 1'b0;
`endif

    for (int i = 0; i < 8; i++)
      addVec($sformatf("reset_off%0d", i), BASE + 32'(4 * i), 1'b0, 4'h0, '0, '0, 1'b0);
    addVec("cmp_full",     A_CMP, 1'b1, 4'hF, 32'h11223344, 32'h11223344, 1'b0);
    addVec("cmp_lane1",    A_CMP, 1'b1, 4'b0010, 32'hAABBCCDD, 32'h1122CC44, 1'b0);
    addVec("cmp_be0",      A_CMP, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h1122CC44, 1'b0);
    addVec("outside_win",  BASE + 32'h28, 1'b0, 4'h0, '0, 32'h0, 1'b1);
    addVec("ctrl_clr_rd0", A_CTRL, 1'b1, 4'hF, 32'hFFFFFFFE, 32'h6, 1'b0);
    addVec("ctrl_zero",    A_CTRL, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0);
    addVec("pre_width",    A_PRE, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0);
    addVec("off6_ro",      BASE + 32'h18, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0);
    addVec("off5_ro",      A_CAP, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0);
    addVec("pre_zero",     A_PRE, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0);

    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    irq("reset_irq", 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].doWr) wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else @(negedge iCLK);
      rd(vecs[i].name, vecs[i].addr, vecs[i].exp, vecs[i].allowZ);
    end

    // Periodic match with reload: (4+1)*(3+1) = 20 cycles
    wr(A_PRE, 32'd3, 4'hF);
    wr(A_CMP, 32'd4, 4'hF);
    wr(A_CTRL, 32'h7, 4'hF);
    rd("per_start_stat", A_STAT, 32'h0);
    repeat (19) @(posedge iCLK);
    #1;
    rd("per_19_stat", A_STAT, 32'h0);
    irq("per_19_irq", 1'b0);
    @(posedge iCLK); #1;
    rd("per_20_stat", A_STAT, 32'h1);
    irq("per_20_irq", 1'b1);
    rd("per_20_cnt", A_CNT, 32'h0);
    wr(A_STAT, 32'h1, 4'h1);
    rd("per_w1c_stat", A_STAT, 32'h0);
    irq("per_w1c_irq", 1'b0);
    repeat (18) @(posedge iCLK);
    #1;
    rd("per_39_stat", A_STAT, 32'h0);
    @(posedge iCLK); #1;
    rd("per_40_stat", A_STAT, 32'h1);
    repeat (20) @(posedge iCLK);
    #1;
    rd("per_overrun", A_STAT, 32'h3);

    // Wrap through all-ones without reload
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'h3, 4'h1);
    wr(A_PRE, 32'h0, 4'hF);
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CNT, 32'hFFFFFFFE, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    rd("wrap_start", A_CNT, 32'hFFFFFFFE);
    foreach (wrapSeq[i]) begin
      @(posedge iCLK); #1;
      rd($sformatf("wrap_cnt%0d", i), A_CNT, wrapSeq[i]);
      rd($sformatf("wrap_stat%0d", i), A_STAT, 32'h0);
    end
    @(posedge iCLK); #1;
    rd("wrap_match", A_STAT, 32'h1);
    rd("wrap_cnt6", A_CNT, 32'h6);

    // Same-cycle hardware set vs W1C, and COUNT write vs tick
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'h3, 4'h1);
    wr(A_CMP, 32'h50, 4'hF);
    wr(A_CNT, 32'h50, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    wr(A_STAT, 32'h1, 4'h1);
    rd("set_beats_w1c", A_STAT, 32'h1);
    rd("set_cnt", A_CNT, 32'h51);
    wr(A_CNT, 32'h100, 4'hF);
    rd("cnt_wr_beats_tick", A_CNT, 32'h100);
    @(posedge iCLK); #1;
    rd("cnt_after_wr", A_CNT, 32'h101);

`ifdef TIMER_CAPTURE_EN
    wr(A_CTRL, 32'h3, 4'hF);
    wr(A_STAT, 32'h7, 4'h1);
    wr(A_CNT, 32'd8, 4'hF);
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    iCapture = 1'b1;
    repeat (4) @(posedge iCLK);
    #1;
    rd("cap_value", A_CAP, 32'd13);
    rd("cap_flag", A_STAT, 32'h4);
    irq("cap_irq", 1'b0);
    iCapture = 1'b0;
`endif

    // Reset mid-count overrides a concurrent write
    wr(A_CTRL, 32'h7, 4'hF);
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    DwAddress = A_CMP; DwWriteData = 32'hFFFFFFFF; DwByteEnable = 4'hF; DwWriteEnable = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0; DwWriteEnable = 1'b0; DwByteEnable = 4'h0;
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_cmp", A_CMP, 32'h0);
    rd("rst_cnt", A_CNT, 32'h0);
    rd("rst_stat", A_STAT, 32'h0);
    irq("rst_irq", 1'b0);
    repeat (3) @(posedge iCLK);
    #1;
    rd("rst_cnt_held", A_CNT, 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
